// File: rtl/swivm_mem_arbiter.sv
// -----------------------------------------------------------------------------
// swivm_mem_arbiter
//
// Shares the single SwiVM main-memory port between two requesters:
//   port 0 - CPU fetch/load/store
//   port 1 - loader/DMA
// One single-word read or write is in flight at a time. A grant issues one
// mem_en cycle, waits MEM_LAT cycles for read data, captures it and pulses
// the winner's ack for one cycle. One IDLE cycle separates transactions.
//
// Optional feature macro: SWIVM_ARB_ROUND_ROBIN_EN
//   defined   - on contention the port not granted last time wins
//   undefined - fixed priority, port 0 over port 1
//
// Parameters:
//   AW      address width (words)
//   DW      data word width
//   MEM_LAT cycles from mem_en sampled high to mem_rdata valid (1..15)
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   req0/we0/addr0/wdata0, ack0    CPU request group and completion pulse
//   req1/we1/addr1/wdata1, ack1    DMA request group and completion pulse
//   rdata                          read data, valid while ack0/ack1 is high
//   mem_en/mem_we/mem_addr/
//   mem_wdata, mem_rdata           memory port
//   busy                           high whenever the FSM is not IDLE
// All outputs are registered.
// -----------------------------------------------------------------------------
module swivm_mem_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    state_t        state, state_nx;
    logic [3:0]    cnt, cnt_nx;
    logic          last_grant, last_grant_nx;
    logic          win, win_nx;          // port owning the current transaction
    logic          txn_we, txn_we_nx;    // write transactions leave rdata alone
    logic          sel;                  // port that would win if granted now

    logic          ack0_nx, ack1_nx, mem_en_nx, mem_we_nx, busy_nx;
    logic [AW-1:0] mem_addr_nx;
    logic [DW-1:0] mem_wdata_nx, rdata_nx;

    // Winner selection; only meaningful when at least one req is high.
    always_comb begin
`ifdef SWIVM_ARB_ROUND_ROBIN_EN
        if (req0 && req1) begin
            sel = ~last_grant;
        end else begin
            sel = ~req0;
        end
`else
        sel = ~req0;
`endif
    end

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        last_grant_nx = last_grant;
        win_nx        = win;
        txn_we_nx     = txn_we;
        ack0_nx       = 1'b0;
        ack1_nx       = 1'b0;
        mem_en_nx     = 1'b0;
        mem_we_nx     = 1'b0;
        mem_addr_nx   = '0;
        mem_wdata_nx  = '0;
        rdata_nx      = rdata;

        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    win_nx        = sel;
                    last_grant_nx = sel;
                    txn_we_nx     = sel ? we1 : we0;
                    mem_en_nx     = 1'b1;
                    mem_we_nx     = sel ? we1 : we0;
                    mem_addr_nx   = sel ? addr1 : addr0;
                    mem_wdata_nx  = sel ? wdata1 : wdata0;
                    state_nx      = ISSUE;
                end
            end
            ISSUE: begin
                cnt_nx   = 4'(MEM_LAT - 1);
                state_nx = WAIT;
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    if (!txn_we) begin
                        rdata_nx = mem_rdata;
                    end
                    // Ack register is loaded here so it is high during ACK.
                    ack0_nx  = ~win;
                    ack1_nx  = win;
                    state_nx = ACK;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            ACK: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            win        <= 1'b0;
            txn_we     <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata      <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            last_grant <= last_grant_nx;
            win        <= win_nx;
            txn_we     <= txn_we_nx;
            ack0       <= ack0_nx;
            ack1       <= ack1_nx;
            rdata      <= rdata_nx;
            mem_en     <= mem_en_nx;
            mem_we     <= mem_we_nx;
            mem_addr   <= mem_addr_nx;
            mem_wdata  <= mem_wdata_nx;
            busy       <= busy_nx;
        end
    end

endmodule

// File: doc/swivm_mem_arbiter.md
Name: swivm_mem_arbiter

Overview:
- Shares the single SwiVM main-memory port between two requesters: port 0 (CPU fetch/load/store) and port 1 (loader/DMA that fills memory before and during a run).
- One transaction is in flight at a time. Each transaction is a single-word read or write.
- Memory read latency is a parameter. The arbiter issues the access, waits for the latency, captures the read data, then acknowledges the requester.
- Sits between the CPU core and the memory model inside the swivm top level.

Parameters:
- AW, 16, address width in words
- DW, 32, data word width
- MEM_LAT, 1, cycles from mem_en sampled high to mem_rdata valid; legal range 1..15

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req0  in  1  CPU request; held high until ack0
- we0  in  1  CPU write enable; 1=write, 0=read
- addr0  in  AW  CPU word address
- wdata0  in  DW  CPU write data
- ack0  out  1  one-cycle transaction complete, CPU
- req1, we1, addr1, wdata1  in  1/1/AW/DW  DMA request group, same semantics as port 0
- ack1  out  1  one-cycle transaction complete, DMA
- rdata  out  DW  read data; valid only in the cycle ack0 or ack1 is high
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- busy  out  1  high in any state other than IDLE

Behaviour:
- Outputs are registered. On reset every output is 0, the state goes to IDLE, the latency counter is cleared, and last_grant is set to 1 so port 0 wins the first tie.
- Reset has priority over everything. An in-flight transaction is abandoned: no ack, and no further mem_en is issued.
- State machine:
  - IDLE: on a clock edge where req0 or req1 is high, the arbiter selects a winner and latches its we, addr and wdata. It drives mem_en=1 with mem_we, mem_addr and mem_wdata for exactly the next cycle, then goes to ISSUE. With no request it stays in IDLE.
  - ISSUE: one cycle with mem_en high. Next state is WAIT, and the counter is loaded with MEM_LAT-1.
  - WAIT: the counter decrements each cycle. When the counter is 0, the arbiter captures mem_rdata into rdata (writes capture nothing and rdata is held), then goes to ACK.
  - ACK: the winner's ack is high for exactly one cycle. Next state is IDLE unconditionally.
- Latency: req sampled in IDLE at edge E, mem_en high in cycle E+1, ack high in cycle E+MEM_LAT+2. One IDLE cycle always separates transactions, so peak throughput is one transaction per MEM_LAT+3 cycles.
- Request and ack handshake:
  - A requester keeps req and its operands stable until it sees its ack, then drops req no later than the edge that ends the ack cycle.
  - The losing requester keeps waiting and is not acknowledged.
  - Operand changes while req is high but the port is not granted are legal. The values sampled at the grant edge are the ones used.
- Arbitration, base behaviour: fixed priority with port 0 over port 1. Port 1 can starve while req0 is continuously asserted.
- mem_en, mem_we, mem_addr and mem_wdata return to 0 outside the ISSUE cycle.
- ack0 and ack1 are never high together.
- Each grant updates last_grant.

Optional Feature:
- Macro: SWIVM_ARB_ROUND_ROBIN_EN.
- When defined: if req0 and req1 are both high in IDLE, the port that was not last granted wins. A single request always wins. DMA therefore gets at least every second slot under contention.
- When undefined: fixed priority to port 0. last_grant is still maintained but ignored.

Test Plan:
- Reset, then CPU read of addr0=0x0010 with memory word 0x0010=0xDEADBEEF and MEM_LAT=1 -> mem_en pulses once with mem_addr=0x0010 and mem_we=0; ack0 goes high 3 cycles after req0 is sampled, with rdata=0xDEADBEEF; ack1 stays 0.
- DMA write addr1=0x0020, wdata1=0x12345678, followed by a CPU read of 0x0020 -> a single mem_en with mem_we=1; ack1 pulses once; the CPU read then returns 0x12345678.
- req0 and req1 held high continuously for 4 transactions, without the macro -> four ack0 pulses and zero ack1. With SWIVM_ARB_ROUND_ROBIN_EN -> the order is ack0, ack1, ack0, ack1.
- MEM_LAT=4, CPU read -> ack0 in cycle E+6; rdata equals mem_rdata from the cycle 4 cycles after mem_en.
- reset asserted during WAIT of a CPU read -> no ack0 and all outputs 0 on the next cycle; after reset is released with req0 still high, a fresh transaction completes normally.
